booth_mul64: RTL
================

BOOTH_MUL64 -- requirements
Module: booth_mul64

Interface
REQ-001 SHALL provide ports, one per line: name  direction  width  meaning.
 clk  in  1  clock, all state changes on rising edge
 reset_n  in  1  reset, asynchronous, active-low
 op_start  in  1  level request to start a multiply
 op_clear  in  1  level request to abort/acknowledge and return to idle
 multiplier  in  64  signed two's-complement operand Q
 multiplicand  in  64  signed two's-complement operand M
 op_done  out  1  registered; high while result is valid
 busy  out  1  registered; high while a multiply is executing
 result  out  128  registered signed product Q*M
REQ-002 SHALL have no parameters; the only build option is in Configuration.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-004 SHALL give op_clear highest priority: when op_clear=1 at an edge, next state is IDLE, result=0, op_done=0, busy=0 and step counter=0, in any state.
REQ-005 In IDLE with op_start=1 and op_clear=0, SHALL latch M and Q, load accumulator {64'b0, Q, 1'b0} (129 bits), set busy=1 and go to EXEC.
REQ-006 SHALL ignore operand changes after the latching edge.
REQ-007 In EXEC (radix-2), SHALL perform one Booth step per edge: pair {acc[1],acc[0]} = 01 adds M to acc[128:65], 10 subtracts M, 00/11 no-op; then arithmetic shift right the 129-bit acc by 1.
REQ-008 Add/subtract SHALL use 65-bit sign-extended M so that M = -2^63 is handled exactly.
REQ-009 After the 64th step, at that same edge, SHALL load result=acc[128:1], set op_done=1, busy=0 and go to DONE; op_done rises exactly 64 edges after the edge that sampled op_start.
REQ-010 SHALL hold result and op_done in DONE until op_clear=1; op_start is ignored in EXEC and DONE.
REQ-011 result SHALL read 0 in IDLE and EXEC and change only on entry to DONE or on clear.
REQ-012 After op_clear returns IDLE, op_start=1 at the next edge (op_clear=0) SHALL start a new multiply.
REQ-013 Simultaneous op_start=1 and op_clear=1 in any state SHALL clear and SHALL NOT start.

Reset
REQ-014 reset_n=0 SHALL asynchronously force state IDLE, op_done=0, busy=0, result=0, accumulator=0, counter=0, latched M=0.
REQ-015 Reset mid-EXEC SHALL discard the operation; no op_done pulse follows release.
REQ-016 After reset_n rises, the first edge with op_start=1 SHALL start normally.

Configuration
REQ-017 Macro BOOTH_RADIX4_EN: when defined, EXEC SHALL use radix-4 Booth recoding (triplet acc[2:0] selects 0, +/-M, +/-2M; shift by 2), completing in 32 steps, op_done rising 32 edges after the start edge.
REQ-018 When BOOTH_RADIX4_EN is undefined, radix-2 per REQ-007 with 64-edge latency; result SHALL be bit-identical in both builds for all operands.
REQ-019 Radix-4 datapath SHALL sign-extend to 66 bits so that 2M for M=-2^63 is exact.

Verification
REQ-020 Q=3, M=5, start pulse then hold op_start=1 -> op_done=1 at edge 64 (32 with BOOTH_RADIX4_EN), result=128'd15, stays in DONE despite op_start=1.
REQ-021 Q=64'h8000_0000_0000_0000, M=same -> result=128'h4000_0000_0000_0000_0000_0000_0000_0000; Q=-1, M=64'h7FFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001.
REQ-022 Q=0, M=64'h1234 -> result=0 with op_done after full latency; then op_clear=1 -> result=0, op_done=0, busy=0 next edge.
REQ-023 op_clear=1 at step 20 of EXEC -> IDLE, no op_done; restart with Q=7, M=-6 -> result=-42 (128'hFFFF...FFD6).
REQ-024 op_start=1 and op_clear=1 together in IDLE -> stays IDLE, busy=0; operands changed from 3 to 9 one edge after start -> result still 15.
REQ-025 reset_n=0 at step 10 -> all outputs 0 immediately, no op_done after release; 1000 random signed pairs vs. reference model in both builds.

Source files
------------

// File: rtl/booth_mul64.sv
// Sequential signed 64x64 Booth multiplier (radix-2, 64 steps by default).
// Define BOOTH_RADIX4_EN to build the radix-4 datapath (32 steps, same result).
module booth_mul64 (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic          op_clear,
  input  logic [63:0]   multiplier,
  input  logic [63:0]   multiplicand,
  output logic          op_done,
  output logic          busy,
  output logic [127:0]  result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef BOOTH_RADIX4_EN
  localparam logic [5:0] LAST_STEP = 6'd31;
`else
  localparam logic [5:0] LAST_STEP = 6'd63;
`endif

  state_t              state, state_nxt;
  logic [5:0]          cnt;
  logic signed [63:0]  m_reg;
  logic signed [128:0] acc;
  logic signed [128:0] acc_step;
  logic                last_step;

  // One radix-2 step: the 65-bit upper field keeps M = -2^63 exact.
  function automatic logic signed [128:0] booth_r2(input logic signed [128:0] a,
                                                    input logic signed [63:0]  m);
    logic signed [64:0]  hi;
    logic signed [64:0]  m65;
    logic signed [129:0] full;
    hi  = {a[128], a[128:65]};
    m65 = {m[63], m};
    case (a[1:0])
      2'b01:   hi = hi + m65;
      2'b10:   hi = hi - m65;
      default: hi = hi;
    endcase
    full = {hi, a[64:0]};
    return full[129:1];
  endfunction

  // One radix-4 step: 66 bits so that 2M for M = -2^63 cannot overflow.
  function automatic logic signed [128:0] booth_r4(input logic signed [128:0] a,
                                                    input logic signed [63:0]  m);
    logic signed [65:0]  hi;
    logic signed [65:0]  m66;
    logic signed [65:0]  m2x;
    logic signed [130:0] full;
    hi  = {{2{a[128]}}, a[128:65]};
    m66 = {{2{m[63]}}, m};
    m2x = {m[63], m, 1'b0};
    case (a[2:0])
      3'b001, 3'b010: hi = hi + m66;
      3'b011:         hi = hi + m2x;
      3'b100:         hi = hi - m2x;
      3'b101, 3'b110: hi = hi - m66;
      default:        hi = hi;
    endcase
    full = {hi, a[64:0]};
    return full[130:2];
  endfunction

  always_comb begin
    acc_step = acc;
`ifdef BOOTH_RADIX4_EN
    acc_step = booth_r4(acc, m_reg);
`else
    acc_step = booth_r2(acc, m_reg);
`endif
  end

  assign last_step = (state == EXEC) && (cnt == LAST_STEP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (op_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (op_start)  state_nxt = EXEC;
        EXEC:    if (last_step) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; clear overrides everything in any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      m_reg   <= '0;
      cnt     <= '0;
      result  <= '0;
      op_done <= 1'b0;
      busy    <= 1'b0;
    end else if (op_clear) begin
      cnt     <= '0;
      result  <= '0;
      op_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_start) begin
            m_reg <= multiplicand;
            acc   <= {64'b0, multiplier, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (last_step) begin
            result  <= acc_step[128:1];
            op_done <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
